// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter
//   Round-robin arbiter that funnels NUM_PORTS data-cache requesters onto a
//   single downstream memory port. Requests and responses are forwarded
//   combinationally. A small read-ID FIFO remembers which port issued each
//   outstanding read, so in-order read data can be routed back to it.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/we/addr/wdata/be  per-port request (packed, port 0 in LSBs)
//   gnt_o, wr_gnt_o       per-port request accepted / write accepted
//   rvalid_o, rdata_o     per-port read data valid, shared read data
//   mem_req_o, mem_*_o    forwarded downstream request
//   mem_gnt_i             downstream accepted the request
//   mem_rvalid_i/rdata_i  downstream read response (in request order)
//   outstanding_o         reads in flight (read-ID FIFO occupancy)
//   err_o                 sticky: response arrived with no read in flight
module dcache_req_arbiter #(
  parameter int NUM_PORTS       = 3,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_PORTS-1:0]              req_valid_i,
  input  logic [NUM_PORTS-1:0]              req_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_be_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              wr_gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [ADDR_WIDTH-1:0]             mem_addr_o,
  output logic [DATA_WIDTH-1:0]             mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           mem_be_o,
  input  logic                              mem_gnt_i,
  input  logic                              mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
  output logic                              err_o
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int BW = DATA_WIDTH / 8;
  localparam int FW = $clog2(MAX_OUTSTANDING);
  localparam int CW = FW + 1;

  // ARB: free arbitration; HOLD: a request was presented but not accepted,
  // so the previously selected port must stay on the bus.
  typedef enum logic {ARB, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   lock_sel_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [FW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic            err_reg;
  // Register array rather than block RAM: the head entry must be readable in
  // the same cycle as mem_rvalid_i to route the response with no latency.
  logic [PW-1:0]   fifo_mem [MAX_OUTSTANDING];

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
  logic [BW-1:0]         be_arr    [NUM_PORTS];
  logic [NUM_PORTS-1:0]  eligible;
  logic                  fifo_has_room;
  logic                  fifo_empty;

  logic [PW-1:0] search_sel;
  logic          search_found;
  logic          hold_active;
  logic [PW-1:0] sel;
  logic          req_any;
  logic          grant;
  logic          push;
  logic          pop;
  logic [PW-1:0] head;

  assign fifo_has_room = (count_reg < CW'(MAX_OUTSTANDING));
  assign fifo_empty    = (count_reg == '0);
  assign head          = fifo_mem[rd_ptr_reg];

  // Unpack the flat per-port buses; a read is only eligible while the ID FIFO
  // has room as of the start of the cycle (a same-cycle pop does not count).
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign addr_arr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[gi]    = req_be_i[gi*BW +: BW];
    assign eligible[gi]  = req_valid_i[gi] & (req_we_i[gi] | fifo_has_room);
  end

  // Round-robin search: first eligible port at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    search_sel   = '0;
    search_found = 1'b0;
    idx          = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!search_found && eligible[idx]) begin
        search_found = 1'b1;
        search_sel   = PW'(idx);
      end
    end
  end

  // A held port keeps the bus; if it withdraws its request the hold is
  // abandoned and normal arbitration resumes in the same cycle.
  always_comb begin
    hold_active = (state_reg == HOLD) && req_valid_i[lock_sel_reg];
    sel         = hold_active ? lock_sel_reg : search_sel;
    req_any     = (hold_active | search_found) & ~rst_i;
    grant       = req_any & mem_gnt_i;
    push        = grant & ~req_we_i[sel];
    pop         = mem_rvalid_i & ~fifo_empty & ~rst_i;
  end

  // Lock state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ARB;
      lock_sel_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_sel_reg <= sel;
    end
  end

  // Lock next-state
  always_comb begin
    state_next = ARB;
    if (req_any && !mem_gnt_i) state_next = HOLD;
  end

  // Outputs
  always_comb begin
    mem_req_o   = req_any;
    mem_we_o    = req_we_i[sel];
    mem_addr_o  = addr_arr[sel];
    mem_wdata_o = wdata_arr[sel];
    mem_be_o    = be_arr[sel];
    gnt_o       = '0;
    if (grant) gnt_o[sel] = 1'b1;
    wr_gnt_o    = gnt_o & req_we_i;
    rvalid_o    = '0;
    if (pop) rvalid_o[head] = 1'b1;
    rdata_o       = mem_rdata_i;
    outstanding_o = count_reg;
    err_o         = err_reg;
  end

  // Round-robin pointer, read-ID FIFO and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (grant) begin
        rr_ptr_reg <= (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + PW'(1);
      end
      if (push) begin
        fifo_mem[wr_ptr_reg] <= sel;
        wr_ptr_reg           <= wr_ptr_reg + FW'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + FW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (mem_rvalid_i && fifo_empty) err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
module tb_dcache_req_arbiter;
  localparam int N  = 3;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = 8;
  localparam int MO = 4;
  localparam int CW = 3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*BW-1:0] req_be;
  logic [N-1:0]    gnt, wr_gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [BW-1:0]   mem_be;
  logic            mem_gnt, mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic [CW-1:0]   outstanding;
  logic            err;

  int tests = 0;
  int fails = 0;

  dcache_req_arbiter #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_be_i(req_be),
    .gnt_o(gnt), .wr_gnt_o(wr_gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [AW-1:0] port_addr(input int p);
    return 64'h0000_1000 + 64'(p) * 64'h40;
  endfunction

  function automatic logic [DW-1:0] port_wdata(input int p);
    return 64'hDA7A_0000_0000_0000 + 64'(p);
  endfunction

  function automatic logic [BW-1:0] port_be(input int p);
    return 8'h0F << p;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  task automatic clear_reqs;
    req_valid = '0;
    req_we    = '0;
  endtask

  task automatic drive(input int p, input logic we);
    req_valid[p]            = 1'b1;
    req_we[p]               = we;
    req_addr[p*AW +: AW]    = port_addr(p);
    req_wdata[p*DW +: DW]   = port_wdata(p);
    req_be[p*BW +: BW]      = port_be(p);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    for (int p = 0; p < N; p++) drive(p, 1'b0);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    #2;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    tests++; if (wr_gnt !== 3'b000) begin fails++; $display("FAIL reset_wr_gnt got=%b exp=000", wr_gnt); end
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
    step();
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    $display("[TB] reset: outstanding=%0d err=%b", outstanding, err);
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_gnt [4];
    int           exp_port [4];
    exp_gnt  = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_port = '{0, 1, 2, 0};
    do_reset();
    for (int p = 0; p < N; p++) drive(p, 1'b0);
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      $display("[TB] rr cycle %0d: gnt=%b addr=%h", i, gnt, mem_addr);
      tests++; if (gnt !== exp_gnt[i]) begin fails++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, gnt, exp_gnt[i]); end
      tests++; if (mem_addr !== port_addr(exp_port[i])) begin fails++; $display("FAIL rr_addr%0d got=%h exp=%h", i, mem_addr, port_addr(exp_port[i])); end
      step();
    end
    #2;
    tests++; if (outstanding !== 3'd4) begin fails++; $display("FAIL rr_outstanding got=%0d exp=4", outstanding); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rr_full_block got=%b exp=0", mem_req); end
    $display("[TB] rr full: outstanding=%0d mem_req=%b", outstanding, mem_req);
    clear_inputs();
    step();
  endtask

  task automatic test_lock;
    do_reset();
    drive(1, 1'b0);
    mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) drive(0, 1'b0);
      #2;
      $display("[TB] lock cycle %0d: mem_req=%b addr=%h gnt=%b", c, mem_req, mem_addr, gnt);
      tests++; if (mem_addr !== port_addr(1)) begin fails++; $display("FAIL lock_addr%0d got=%h exp=%h", c, mem_addr, port_addr(1)); end
      tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL lock_gnt%0d got=%b exp=000", c, gnt); end
      step();
    end
    mem_gnt = 1'b1;
    #2;
    $display("[TB] lock cycle 3: gnt=%b", gnt);
    tests++; if (gnt !== 3'b010) begin fails++; $display("FAIL lock_release_gnt got=%b exp=010", gnt); end
    step();
    req_valid[1] = 1'b0;
    #2;
    $display("[TB] lock cycle 4: gnt=%b addr=%h", gnt, mem_addr);
    tests++; if (gnt !== 3'b001) begin fails++; $display("FAIL lock_next_gnt got=%b exp=001", gnt); end
    tests++; if (mem_addr !== port_addr(0)) begin fails++; $display("FAIL lock_next_addr got=%h exp=%h", mem_addr, port_addr(0)); end
    clear_inputs();
    step();
  endtask

  task automatic test_full_write_and_responses;
    int            order [4];
    logic [N-1:0]  exp_rv [4];
    logic [DW-1:0] dat [4];
    order  = '{2, 0, 1, 2};
    exp_rv = '{3'b100, 3'b001, 3'b010, 3'b100};
    dat    = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
               64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};
    do_reset();
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clear_reqs();
      drive(order[i], 1'b0);
      #2;
      $display("[TB] fill read %0d: gnt=%b", i, gnt);
      tests++; if (gnt !== (3'b001 << order[i])) begin fails++; $display("FAIL fill_gnt%0d got=%b exp=%b", i, gnt, 3'b001 << order[i]); end
      step();
    end
    clear_reqs();
    tests++; if (outstanding !== 3'd4) begin fails++; $display("FAIL fill_outstanding got=%0d exp=4", outstanding); end
    drive(0, 1'b1);
    drive(1, 1'b0);
    drive(2, 1'b0);
    #2;
    $display("[TB] write while full: gnt=%b wr_gnt=%b we=%b", gnt, wr_gnt, mem_we);
    tests++; if (wr_gnt !== 3'b001) begin fails++; $display("FAIL full_wr_gnt got=%b exp=001", wr_gnt); end
    tests++; if (gnt !== 3'b001) begin fails++; $display("FAIL full_gnt got=%b exp=001", gnt); end
    tests++; if (mem_we !== 1'b1) begin fails++; $display("FAIL full_we got=%b exp=1", mem_we); end
    tests++; if (mem_wdata !== port_wdata(0)) begin fails++; $display("FAIL full_wdata got=%h exp=%h", mem_wdata, port_wdata(0)); end
    tests++; if (mem_be !== port_be(0)) begin fails++; $display("FAIL full_be got=%h exp=%h", mem_be, port_be(0)); end
    step();
    req_valid[0] = 1'b0;
    #2;
    $display("[TB] reads while full: mem_req=%b outstanding=%0d", mem_req, outstanding);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL full_read_block got=%b exp=0", mem_req); end
    tests++; if (outstanding !== 3'd4) begin fails++; $display("FAIL full_after_write got=%0d exp=4", outstanding); end
    clear_reqs();
    mem_gnt = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = dat[i];
      #2;
      $display("[TB] resp %0d: rvalid=%b rdata=%h", i, rvalid, rdata);
      tests++; if (rvalid !== exp_rv[i]) begin fails++; $display("FAIL resp_rvalid%0d got=%b exp=%b", i, rvalid, exp_rv[i]); end
      tests++; if (rdata !== dat[i]) begin fails++; $display("FAIL resp_rdata%0d got=%h exp=%h", i, rdata, dat[i]); end
      step();
    end
    mem_rvalid = 1'b0;
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL resp_outstanding got=%0d exp=0", outstanding); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL resp_err got=%b exp=0", err); end
    clear_inputs();
    step();
  endtask

  task automatic test_simultaneous;
    do_reset();
    mem_gnt = 1'b1;
    drive(0, 1'b0);
    step();
    clear_reqs();
    drive(1, 1'b0);
    step();
    clear_reqs();
    tests++; if (outstanding !== 3'd2) begin fails++; $display("FAIL simul_pre got=%0d exp=2", outstanding); end
    drive(2, 1'b0);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hEEEE_0000_0000_000E;
    #2;
    $display("[TB] simul: gnt=%b rvalid=%b rdata=%h", gnt, rvalid, rdata);
    tests++; if (gnt !== 3'b100) begin fails++; $display("FAIL simul_gnt got=%b exp=100", gnt); end
    tests++; if (rvalid !== 3'b001) begin fails++; $display("FAIL simul_rvalid got=%b exp=001", rvalid); end
    tests++; if (rdata !== 64'hEEEE_0000_0000_000E) begin fails++; $display("FAIL simul_rdata got=%h exp=%h", rdata, 64'hEEEE_0000_0000_000E); end
    step();
    clear_reqs();
    tests++; if (outstanding !== 3'd2) begin fails++; $display("FAIL simul_outstanding got=%0d exp=2", outstanding); end
    #2;
    tests++; if (rvalid !== 3'b010) begin fails++; $display("FAIL simul_drain0 got=%b exp=010", rvalid); end
    step();
    #2;
    tests++; if (rvalid !== 3'b100) begin fails++; $display("FAIL simul_drain1 got=%b exp=100", rvalid); end
    step();
    mem_rvalid = 1'b0;
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL simul_drained got=%0d exp=0", outstanding); end
    $display("[TB] simul drained: outstanding=%0d err=%b", outstanding, err);
    clear_inputs();
    step();
  endtask

  task automatic test_error_and_midreset;
    do_reset();
    mem_rvalid = 1'b1;
    #2;
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL err_rvalid got=%b exp=000", rvalid); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_before got=%b exp=0", err); end
    step();
    mem_rvalid = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_set got=%b exp=1", err); end
    step();
    step();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", err); end
    $display("[TB] spurious rvalid: err=%b", err);
    mem_gnt = 1'b1;
    for (int p = 0; p < N; p++) drive(p, 1'b0);
    repeat (3) step();
    clear_reqs();
    tests++; if (outstanding !== 3'd3) begin fails++; $display("FAIL midrst_pre got=%0d exp=3", outstanding); end
    rst = 1'b1;
    drive(0, 1'b0);
    #2;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL midrst_mem_req got=%b exp=0", mem_req); end
    tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL midrst_gnt got=%b exp=000", gnt); end
    step();
    rst = 1'b0;
    clear_inputs();
    tests++; if (outstanding !== 3'd0) begin fails++; $display("FAIL midrst_outstanding got=%0d exp=0", outstanding); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL midrst_err got=%b exp=0", err); end
    mem_rvalid = 1'b1;
    #2;
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL stale_rvalid got=%b exp=000", rvalid); end
    step();
    mem_rvalid = 1'b0;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL stale_err got=%b exp=1", err); end
    $display("[TB] stale rvalid after reset: err=%b", err);
    clear_inputs();
    step();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_full_write_and_responses();
    test_simultaneous();
    test_error_and_midreset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
